bitfusion_seq: RTL

Job sequencer for one fusion unit. Accepts a dot-product job command (operand precisions, signedness, vector length, bias) and streams operand beats into the fusion unit with the job's precision configuration held stable. Accumulates the unit's four-lane partial sums and returns the reduced result through a valid/ready port. Sits between the operand buffers and a single fusion unit; one job in flight at a time.

---
 rtl/bitfusion_pkg.sv | 33 +++
 rtl/bitfusion_lane_acc.sv | 81 ++++++++
 rtl/bitfusion_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bitfusion_pkg.sv
// ---------------------------------------------------------------------------
// bitfusion_pkg
// Shared definitions for the fusion-unit job sequencer:
//   - bf_state_e      : sequencer FSM states
//   - BF_W1..BF_W8    : the operand widths the fusion unit supports
//   - bf_width_legal  : true when a width field holds one of those widths
//   - bf_lane_lsb     : bit offset of a lane inside a packed psum bus
// Optional feature macro used by the importing files: BF_SEQ_SAT_EN.
// ---------------------------------------------------------------------------
package bitfusion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } bf_state_e;

  localparam logic [3:0] BF_W1 = 4'd1;
  localparam logic [3:0] BF_W2 = 4'd2;
  localparam logic [3:0] BF_W4 = 4'd4;
  localparam logic [3:0] BF_W8 = 4'd8;

  function automatic logic bf_width_legal(input logic [3:0] w);
    return (w == BF_W1) || (w == BF_W2) || (w == BF_W4) || (w == BF_W8);
  endfunction

  // Lane l of a packed bus occupies [l*col_w +: col_w]; lane 0 in the LSBs.
  function automatic int bf_lane_lsb(input int lane, input int col_w);
    return lane * col_w;
  endfunction

endpackage

// File: rtl/bitfusion_lane_acc.sv
// ---------------------------------------------------------------------------
// bitfusion_lane_acc
// One COL_WIDTH-bit lane accumulator. Wraps modulo 2^COL_WIDTH by default;
// with BF_SEQ_SAT_EN defined it saturates (signed or unsigned range chosen
// by signed_i) and keeps a sticky overflow flag.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr_i        clear accumulator and overflow flag (takes priority)
//   en_i         add psum_i this cycle
//   signed_i     (BF_SEQ_SAT_EN only) saturate to the signed range
//   psum_i       lane partial sum from the fusion unit
//   acc_o        accumulated value
//   ovf_o        sticky overflow (always 0 in the wrapping build)
// ---------------------------------------------------------------------------
module bitfusion_lane_acc #(
  parameter int COL_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
`ifdef BF_SEQ_SAT_EN
  input  logic                 signed_i,
`endif
  input  logic [COL_WIDTH-1:0] psum_i,
  output logic [COL_WIDTH-1:0] acc_o,
  output logic                 ovf_o
);

  logic [COL_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

`ifdef BF_SEQ_SAT_EN
  logic [COL_WIDTH:0] sum_w;
  assign sum_w = {1'b0, acc_q} + {1'b0, psum_i};
`endif

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
`ifdef BF_SEQ_SAT_EN
      if (signed_i) begin
        // Signed overflow: operands share a sign and the result sign differs.
        if ((acc_q[COL_WIDTH-1] == psum_i[COL_WIDTH-1]) &&
            (sum_w[COL_WIDTH-1] != acc_q[COL_WIDTH-1])) begin
          ovf_d = 1'b1;
          acc_d = acc_q[COL_WIDTH-1] ? {1'b1, {(COL_WIDTH-1){1'b0}}}
                                     : {1'b0, {(COL_WIDTH-1){1'b1}}};
        end else begin
          acc_d = sum_w[COL_WIDTH-1:0];
        end
      end else if (sum_w[COL_WIDTH]) begin
        ovf_d = 1'b1;
        acc_d = '1;
      end else begin
        acc_d = sum_w[COL_WIDTH-1:0];
      end
`else
      acc_d = acc_q + psum_i;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/bitfusion_seq.sv
// ---------------------------------------------------------------------------
// bitfusion_seq
// Job sequencer for a single fusion unit. Takes one dot-product job command,
// streams operand beats into the unit with the job's precision config held,
// accumulates the four returned psum lanes and hands back the result.
// Optional feature: define BF_SEQ_SAT_EN for saturating lane accumulation
// (overflow reported on res_err).
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   cmd_*                            job command (valid/ready), widths,
//                                    signedness, len_m1, first-beat bias
//   op_valid/op_ready, op_in/op_weight  operand beats
//   fu_in/fu_weight/fu_psum_in       registered operands to the unit
//   fu_*_width, fu_s_*               job config held for the whole job
//   fu_psum_fwd                      unit output, FU_LAT cycles after fu_in
//   res_valid/res_ready, res_data, res_err   result port
//   busy                             sequencer not idle
// ---------------------------------------------------------------------------
module bitfusion_seq
  import bitfusion_pkg::*;
#(
  parameter int COL_WIDTH = 13,
  parameter int FU_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_in_width,
  input  logic [3:0]             cmd_weight_width,
  input  logic                   cmd_s_in,
  input  logic                   cmd_s_weight,
  input  logic [7:0]             cmd_len_m1,
  input  logic [4*COL_WIDTH-1:0] cmd_bias,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [7:0]             op_in,
  input  logic [7:0]             op_weight,
  output logic [7:0]             fu_in,
  output logic [7:0]             fu_weight,
  output logic [4*COL_WIDTH-1:0] fu_psum_in,
  output logic [3:0]             fu_in_width,
  output logic [3:0]             fu_weight_width,
  output logic                   fu_s_in,
  output logic                   fu_s_weight,
  input  logic [4*COL_WIDTH-1:0] fu_psum_fwd,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*COL_WIDTH-1:0] res_data,
  output logic                   res_err,
  output logic                   busy
);

  localparam int PW = 4 * COL_WIDTH;

  bf_state_e        state_q, state_d;
  logic [3:0]       in_w_q, wt_w_q;
  logic             s_in_q, s_wt_q;
  logic [7:0]       len_q;
  logic [PW-1:0]    bias_q;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             cfg_load;
  logic             acc_clr;
  logic [7:0]       fu_in_q, fu_in_d, fu_wt_q, fu_wt_d;
  logic [PW-1:0]    fu_psum_q, fu_psum_d;
  // fu_valid_q marks a real beat on fu_in; tag_q follows it for FU_LAT
  // cycles so the tail lines up with the matching fu_psum_fwd.
  logic             fu_valid_q, fu_valid_d;
  logic [FU_LAT-1:0] tag_q;
  logic [FU_LAT-1:0] tag_early;
  logic             tag_tail;
  logic [PW-1:0]    acc_bus;
  logic [3:0]       ovf_vec;

  assign tag_tail = tag_q[FU_LAT-1];

  always_comb begin
    tag_early           = tag_q;
    tag_early[FU_LAT-1] = 1'b0;
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    cfg_load   = 1'b0;
    acc_clr    = 1'b0;
    fu_in_d    = '0;
    fu_wt_d    = '0;
    fu_psum_d  = '0;
    fu_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cfg_load = 1'b1;
          acc_clr  = 1'b1;
          cnt_d    = '0;
          if (bf_width_legal(cmd_in_width) && bf_width_legal(cmd_weight_width)) begin
            err_d   = 1'b0;
            state_d = ST_STREAM;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_STREAM: begin
        if (op_valid) begin
          fu_in_d    = op_in;
          fu_wt_d    = op_weight;
          fu_psum_d  = (cnt_q == 8'd0) ? bias_q : '0;
          fu_valid_d = 1'b1;
          if (cnt_q == len_q) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_DRAIN: begin
        // Only the tail may still hold a beat: it is accumulated on this
        // same edge, so the result is complete in the next cycle.
        if (!fu_valid_q && (tag_early == '0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_w_q     <= '0;
      wt_w_q     <= '0;
      s_in_q     <= 1'b0;
      s_wt_q     <= 1'b0;
      len_q      <= '0;
      bias_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      fu_in_q    <= '0;
      fu_wt_q    <= '0;
      fu_psum_q  <= '0;
      fu_valid_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      fu_in_q    <= fu_in_d;
      fu_wt_q    <= fu_wt_d;
      fu_psum_q  <= fu_psum_d;
      fu_valid_q <= fu_valid_d;
      tag_q[0]   <= fu_valid_q;
      for (int k = 1; k < FU_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      if (cfg_load) begin
        in_w_q <= cmd_in_width;
        wt_w_q <= cmd_weight_width;
        s_in_q <= cmd_s_in;
        s_wt_q <= cmd_s_weight;
        len_q  <= cmd_len_m1;
        bias_q <= cmd_bias;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam int LSB = bf_lane_lsb(gi, COL_WIDTH);
      bitfusion_lane_acc #(.COL_WIDTH(COL_WIDTH)) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (acc_clr),
        .en_i     (tag_tail),
`ifdef BF_SEQ_SAT_EN
        .signed_i (s_in_q | s_wt_q),
`endif
        .psum_i   (fu_psum_fwd[LSB +: COL_WIDTH]),
        .acc_o    (acc_bus[LSB +: COL_WIDTH]),
        .ovf_o    (ovf_vec[gi])
      );
    end
  endgenerate

  assign cmd_ready       = (state_q == ST_IDLE);
  assign op_ready        = (state_q == ST_STREAM);
  assign res_valid       = (state_q == ST_DONE);
  assign busy            = (state_q != ST_IDLE);
  assign fu_in           = fu_in_q;
  assign fu_weight       = fu_wt_q;
  assign fu_psum_in      = fu_psum_q;
  assign fu_in_width     = in_w_q;
  assign fu_weight_width = wt_w_q;
  assign fu_s_in         = s_in_q;
  assign fu_s_weight     = s_wt_q;
  // Accumulators are cleared at command accept, so an illegal-width job
  // returns zero. ovf_vec stays 0 unless saturation is built in.
  assign res_data        = res_valid ? acc_bus : '0;
  assign res_err         = res_valid & (err_q | (|ovf_vec));

endmodule
